mult_pipe: RTL and testbench
============================

// Module: mult_pipe
// PURPOSE
//   Parametrised, fully back-pressurable pipelined multiplier with AXI-stream operands and result.
//   Successor to the fixed 18x18 multiplier: generic operand widths, configurable depth, optional signed mode.
//   Every stage carries its own valid bit, so results drain when no new operands arrive.
//   Used by the ElGamal datapath as the leaf multiplier under the modular-multiply and exponentiation blocks.
// PARAMETERS
//   WIDTH_A   18  operand A width (bits), >=2
//   WIDTH_B   18  operand B width (bits), >=2
//   STAGES    4   pipeline depth = accept-to-output latency in cycles, >=2
//   SIGNED    0   0: unsigned product; 1: two's-complement signed product
// PORTS
//   clk             in   1          clock, all logic on rising edge
//   rst_n           in   1          asynchronous active-low reset
//   input_a_tdata   in   WIDTH_A    operand A
//   input_a_tvalid  in   1          operand A valid
//   input_a_tready  out  1          operand A accepted
//   input_b_tdata   in   WIDTH_B    operand B
//   input_b_tvalid  in   1          operand B valid
//   input_b_tready  out  1          operand B accepted
//   output_tdata    out  WIDTH_A+WIDTH_B  product
//   output_tvalid   out  1          product valid
//   output_tready   in   1          downstream ready
//   busy            out  1          any stage holds valid data
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync deassert by top level): all stage valids 0, data regs 0;
//     output_tvalid=0, output_tdata=0, busy=0, both treadys 0 while in reset.
//   - Pair handshake: accept = a_tvalid & b_tvalid & in_ready. a_tready = b_tvalid & in_ready;
//     b_tready = a_tvalid & in_ready. A lone operand is never consumed.
//   - Stage s (0..STAGES-1) holds v[s] + data. adv[STAGES-1] = output_tready | ~v[STAGES-1];
//     adv[s] = adv[s+1] | ~v[s] (bubble collapsing). in_ready = adv[0].
//   - Stage 0 registers operands; stage 1 registers the full product; stages 2..STAGES-1 are delay slices.
//   - On adv[s]: v[s] <= (s==0 ? accept : v[s-1]); data updates only when the incoming valid is 1.
//   - Product width exactly WIDTH_A+WIDTH_B, no truncation/overflow. SIGNED=1 sign-extends both operands.
//   - Latency: result of the pair accepted at cycle N is on output_tdata with tvalid at cycle N+STAGES
//     if output_tready stayed high. Throughput 1 product/cycle.
//   - Backpressure: output_tdata/tvalid stable while tvalid & ~tready. Holding tready low fills all
//     STAGES slots, then in_ready=0. No product is dropped or duplicated; order preserved.
//   - Simultaneous output pop and input accept with a full pipeline is legal (in_ready=1 that cycle).
//   - Reset mid-operation: all in-flight products discarded; first post-reset output is a fresh pair.
//   - busy = OR of v[].
// CONFIGURATION
//   MULT_PIPE_TLAST_EN defined: adds ports input_tlast (in, 1, sampled with operand A on accept) and
//     output_tlast (out, 1); tlast travels with its product through every stage; reset value 0.
//   Not defined: no tlast ports, no tlast storage.
// STRUCTURE
//   Shared package mult_pkg: default width constants (MULT_W=18), localparam function for product width.
//   One sub-module: mult_pipe_slice -- one valid+data register slice with load enable, instantiated
//     for the delay stages 2..STAGES-1 via generate.
// TESTING
//   1. Reset, then 8 back-to-back pairs (3x5, 0x1, max*max, ...), tready=1 -> products 15, 0,
//      (2^18-1)^2, ... appear STAGES cycles after acceptance, one per cycle, in order.
//   2. Single pair 7x9 then no further input -> 63 emerges after STAGES cycles (no stall on idle input).
//   3. output_tready=0 for 20 cycles while streaming -> exactly STAGES products held, in_ready drops,
//      data stable; on release all delivered in order, none lost.
//   4. A valid only (B idle) for 10 cycles -> a_tready=0, nothing accepted; B asserted -> one pair accepted.
//   5. SIGNED=1, WIDTH 8x8: -3 x 5 -> output 16'hFFF1; -128 x -128 -> 16'h4000.
//   6. rst_n pulsed low with full pipeline -> outputs 0 immediately; after release a new pair 2x2 -> 4.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and width helpers for the pipelined multiplier family.
package mult_pkg;

  localparam int unsigned MULT_W      = 18;
  localparam int unsigned MULT_STAGES = 4;

  // Full-precision product width for a WA x WB multiply.
  function automatic int unsigned prod_width(input int unsigned wa, input int unsigned wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/mult_pipe_slice.sv
// One valid+data register slice with load enable; data only captured when the incoming valid is set.
module mult_pipe_slice #(
  parameter int unsigned W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Back-pressurable pipelined multiplier with AXI-stream operand pair and result.
// Optional MULT_PIPE_TLAST_EN adds input_tlast/output_tlast carried alongside each product.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = MULT_W,
  parameter int unsigned WIDTH_B = MULT_W,
  parameter int unsigned STAGES  = MULT_STAGES,
  parameter int unsigned SIGNED  = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [WIDTH_A-1:0]                       input_a_tdata,
  input  logic                                     input_a_tvalid,
  output logic                                     input_a_tready,
  input  logic [WIDTH_B-1:0]                       input_b_tdata,
  input  logic                                     input_b_tvalid,
  output logic                                     input_b_tready,
  output logic [prod_width(WIDTH_A, WIDTH_B)-1:0]  output_tdata,
  output logic                                     output_tvalid,
  input  logic                                     output_tready,
`ifdef MULT_PIPE_TLAST_EN
  input  logic                                     input_tlast,
  output logic                                     output_tlast,
`endif
  output logic                                     busy
);

  localparam int unsigned PW  = prod_width(WIDTH_A, WIDTH_B);
  localparam bit          SGN = (SIGNED != 0);
`ifdef MULT_PIPE_TLAST_EN
  localparam int unsigned DW  = PW + 1;
`else
  localparam int unsigned DW  = PW;
`endif

  logic          v   [STAGES];
  logic          adv [STAGES];
  logic [DW-1:0] d   [1:STAGES-1];

  logic               v0;
  logic               v1;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic [DW-1:0]      d1;
`ifdef MULT_PIPE_TLAST_EN
  logic               tl0;
`endif

  logic          in_ready_c;
  logic          accept_c;
  logic [PW-1:0] ext_a_c;
  logic [PW-1:0] ext_b_c;
  logic [PW-1:0] prod_c;

  // A stage may advance if any slot at or downstream of it is empty, or the sink pops.
  always_comb begin
    logic hole;
    for (int s = 0; s < int'(STAGES); s++) begin
      adv[s] = 1'b0;
    end
    hole = output_tready;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      hole   = hole | ~v[s];
      adv[s] = hole;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < int'(STAGES); s++) begin
      busy = busy | v[s];
    end
  end

  // Readies are forced low while reset is held.
  assign in_ready_c     = adv[0] & rst_n;
  assign accept_c       = input_a_tvalid & input_b_tvalid & in_ready_c;
  assign input_a_tready = input_b_tvalid & in_ready_c;
  assign input_b_tready = input_a_tvalid & in_ready_c;

  // Extending both operands to the full product width makes the truncated product exact in either mode.
  assign ext_a_c = {{WIDTH_B{SGN & a_q[WIDTH_A-1]}}, a_q};
  assign ext_b_c = {{WIDTH_A{SGN & b_q[WIDTH_B-1]}}, b_q};
  assign prod_c  = ext_a_c * ext_b_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0  <= 1'b0;
      a_q <= '0;
      b_q <= '0;
`ifdef MULT_PIPE_TLAST_EN
      tl0 <= 1'b0;
`endif
      v1  <= 1'b0;
      d1  <= '0;
    end else begin
      if (adv[0]) begin
        v0 <= accept_c;
        if (accept_c) begin
          a_q <= input_a_tdata;
          b_q <= input_b_tdata;
`ifdef MULT_PIPE_TLAST_EN
          tl0 <= input_tlast;
`endif
        end
      end
      if (adv[1]) begin
        v1 <= v0;
        if (v0) begin
`ifdef MULT_PIPE_TLAST_EN
          d1 <= {tl0, prod_c};
`else
          d1 <= prod_c;
`endif
        end
      end
    end
  end

  assign v[0] = v0;
  assign v[1] = v1;
  assign d[1] = d1;

  // Pure delay slices behind the product register.
  for (genvar s = 2; s < STAGES; s++) begin : g_delay
    mult_pipe_slice #(
      .W (DW)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (adv[s]),
      .in_valid  (v[s-1]),
      .in_data   (d[s-1]),
      .out_valid (v[s]),
      .out_data  (d[s])
    );
  end

  assign output_tvalid = v[STAGES-1];
  assign output_tdata  = d[STAGES-1][PW-1:0];
`ifdef MULT_PIPE_TLAST_EN
  assign output_tlast  = d[STAGES-1][PW];
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: unsigned 18x18 pipeline plus a signed 8x8 instance.
module tb_mult_pipe;

  localparam int STG  = 4;
  localparam int SSTG = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] a_d, b_d;
  logic        a_v, b_v, rdy;
  logic        a_rdy, b_rdy;
  logic [35:0] o_d;
  logic        o_v;
  logic        busy;
  logic        tl_in;
  logic        tl_out;

  logic [7:0]  s_a, s_b;
  logic        s_av, s_bv;
  logic        s_ardy, s_brdy;
  logic [15:0] s_o;
  logic        s_ov;
  logic        s_busy;
  logic        s_tl_out;

  always #5 clk = ~clk;

  mult_pipe #(.WIDTH_A(18), .WIDTH_B(18), .STAGES(STG), .SIGNED(0)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_a_tdata  (a_d),
    .input_a_tvalid (a_v),
    .input_a_tready (a_rdy),
    .input_b_tdata  (b_d),
    .input_b_tvalid (b_v),
    .input_b_tready (b_rdy),
    .output_tdata   (o_d),
    .output_tvalid  (o_v),
    .output_tready  (rdy),
`ifdef MULT_PIPE_TLAST_EN
    .input_tlast    (tl_in),
    .output_tlast   (tl_out),
`endif
    .busy           (busy)
  );

  mult_pipe #(.WIDTH_A(8), .WIDTH_B(8), .STAGES(SSTG), .SIGNED(1)) u_sgn (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_a_tdata  (s_a),
    .input_a_tvalid (s_av),
    .input_a_tready (s_ardy),
    .input_b_tdata  (s_b),
    .input_b_tvalid (s_bv),
    .input_b_tready (s_brdy),
    .output_tdata   (s_o),
    .output_tvalid  (s_ov),
    .output_tready  (1'b1),
`ifdef MULT_PIPE_TLAST_EN
    .input_tlast    (1'b0),
    .output_tlast   (s_tl_out),
`endif
    .busy           (s_busy)
  );

  typedef struct {
    logic [35:0] p;
    int          t;
    logic        tl;
  } exp_t;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] p;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } svec_t;

  exp_t        q[$];
  vec_t        tab[8];
  svec_t       stab[7];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          exact_lat;
  bit          stall_prev;
  logic [35:0] held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] umul(input logic [17:0] a, input logic [17:0] b);
    logic [35:0] x, y;
    x = {18'd0, a};
    y = {18'd0, b};
    return x * y;
  endfunction

  function automatic logic [17:0] rnd18();
    case ($urandom_range(0, 5))
      0:       return 18'd0;
      1:       return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  // One clock of stimulus; the model predicts readiness, pops and pushes from occupancy alone.
  task automatic step(input logic av, input logic [17:0] a, input logic bv, input logic [17:0] b,
                      input logic r, input logic tl, input logic [35:0] p);
    logic exp_rdy;
    exp_t e;
    @(negedge clk);
    a_v = av; a_d = a; b_v = bv; b_d = b; rdy = r; tl_in = tl;
    #1;
    if (stall_prev) begin
      chk("hold_valid", 64'(o_v), 64'd1);
      chk("hold_data", 64'(o_d), 64'(held));
    end
    chk("busy", 64'(busy), 64'(q.size() != 0));
    exp_rdy = (q.size() < STG) || r;
    chk("a_tready", 64'(a_rdy), 64'(bv && exp_rdy));
    chk("b_tready", 64'(b_rdy), 64'(av && exp_rdy));
    if (o_v && r) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(o_v), 64'd0);
      end else begin
        e = q.pop_front();
        chk("data", 64'(o_d), 64'(e.p));
        if (exact_lat) chk("latency", 64'(cyc - e.t), 64'(STG));
`ifdef MULT_PIPE_TLAST_EN
        chk("tlast", 64'(tl_out), 64'(e.tl));
`endif
      end
    end
    if (av && bv && exp_rdy) begin
      e.p = p; e.t = cyc; e.tl = tl;
      q.push_back(e);
    end
    stall_prev = o_v && !r;
    held = o_d;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) step(1'b0, 18'd0, 1'b0, 18'd0, 1'b1, 1'b0, 36'd0);
    chk("drain_empty", 64'(q.size()), 64'd0);
    step(1'b0, 18'd0, 1'b0, 18'd0, 1'b1, 1'b0, 36'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [17:0] ra, rb;
    logic        rtl;
    int          oi;

    tab[0] = '{18'd3,       18'd5,       36'd15};
    tab[1] = '{18'd0,       18'd1,       36'd0};
    tab[2] = '{18'h3FFFF,   18'h3FFFF,   36'hF_FFF8_0001};
    tab[3] = '{18'd1,       18'h3FFFF,   36'h0_0003_FFFF};
    tab[4] = '{18'h3FFFF,   18'd1,       36'h0_0003_FFFF};
    tab[5] = '{18'h20000,   18'd2,       36'h0_0004_0000};
    tab[6] = '{18'd1000,    18'd1000,    36'd1000000};
    tab[7] = '{18'h3FFFF,   18'h20000,   36'h7_FFFE_0000};

    stab[0] = '{8'hFD, 8'h05, 16'hFFF1};
    stab[1] = '{8'h80, 8'h80, 16'h4000};
    stab[2] = '{8'h7F, 8'h80, 16'hC080};
    stab[3] = '{8'hFF, 8'hFF, 16'h0001};
    stab[4] = '{8'h00, 8'hFB, 16'h0000};
    stab[5] = '{8'h7F, 8'h7F, 16'h3F01};
    stab[6] = '{8'hFF, 8'h01, 16'hFFFF};

    // Reset with both operands offered: readies must stay low.
    rst_n = 1'b0; a_v = 1'b1; b_v = 1'b1; a_d = 18'd3; b_d = 18'd3; rdy = 1'b1; tl_in = 1'b0;
    s_av = 1'b0; s_bv = 1'b0; s_a = 8'd0; s_b = 8'd0;
    exact_lat = 1'b0; stall_prev = 1'b0; held = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tvalid", 64'(o_v), 64'd0);
    chk("rst_tdata", 64'(o_d), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_a_tready", 64'(a_rdy), 64'd0);
    chk("rst_b_tready", 64'(b_rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; a_v = 1'b0; b_v = 1'b0;

    // Back-to-back table vectors at full rate.
    exact_lat = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, tab[i].a, 1'b1, tab[i].b, 1'b1, 1'(i == 7), tab[i].p);
    drain();

    // Single pair then idle input.
    step(1'b1, 18'd7, 1'b1, 18'd9, 1'b1, 1'b1, 36'd63);
    drain();

    // Sink stalled for 20 cycles while the source keeps offering.
    exact_lat = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra = rnd18(); rb = rnd18();
      step(1'b1, ra, 1'b1, rb, 1'b0, 1'b0, umul(ra, rb));
    end
    chk("held_count", 64'(q.size()), 64'(STG));
    chk("stall_in_ready", 64'(a_rdy), 64'd0);
    drain();

    // Lone operand A is never consumed.
    for (int i = 0; i < 10; i++) step(1'b1, 18'd11, 1'b0, 18'd13, 1'b1, 1'b0, 36'd143);
    chk("lone_a", 64'(q.size()), 64'd0);
    step(1'b1, 18'd11, 1'b1, 18'd13, 1'b1, 1'b0, 36'd143);
    chk("pair_accept", 64'(q.size()), 64'd1);
    drain();

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      ra = rnd18(); rb = rnd18(); rtl = 1'($urandom);
      step(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 3) != 0), rb,
           1'($urandom_range(0, 2) != 0), rtl, umul(ra, rb));
    end
    drain();

    // Reset with a full pipeline discards everything in flight.
    for (int k = 0; k < 20 && q.size() < STG; k++) begin
      ra = rnd18(); rb = rnd18();
      step(1'b1, ra, 1'b1, rb, 1'b0, 1'b0, umul(ra, rb));
    end
    chk("prefill", 64'(q.size()), 64'(STG));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(o_v), 64'd0);
    chk("midrst_tdata", 64'(o_d), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_a_tready", 64'(a_rdy), 64'd0);
    q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    a_v = 1'b0; b_v = 1'b0; rdy = 1'b1;
    rst_n = 1'b1;
    exact_lat = 1'b1;
    step(1'b1, 18'd2, 1'b1, 18'd2, 1'b1, 1'b0, 36'd4);
    drain();

    // Signed 8x8 instance: table streamed back-to-back.
    oi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 7) begin
        s_av = 1'b1; s_bv = 1'b1; s_a = stab[k].a; s_b = stab[k].b;
      end else begin
        s_av = 1'b0; s_bv = 1'b0;
      end
      #1;
      if (s_ov) begin
        if (oi < 7) begin
          chk("s_data", 64'(s_o), 64'(stab[oi].p));
          chk("s_latency", 64'(k - oi), 64'(SSTG));
          oi++;
        end else begin
          chk("s_spurious", 64'(s_ov), 64'd0);
        end
      end
    end
    chk("s_count", 64'(oi), 64'd7);
    chk("s_busy_idle", 64'(s_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
